// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: one outstanding memory read at a time, results queued in a small FIFO for the core.
// Define INST_PREFETCH_PERF_EN to add the fetch_count output, which counts instructions accepted by the core.
module inst_prefetch #(
  parameter int Mbit  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Mbit-1:0] start_pc,
  input  logic            redirect,
  input  logic [Mbit-1:0] redirect_pc,
  output logic            mem_req,
  output logic [Mbit-1:0] mem_adr,
  input  logic            mem_ack,
  input  logic [Mbit-1:0] mem_data,
  output logic            inst_valid,
  output logic [Mbit-1:0] inst,
  output logic [Mbit-1:0] inst_pc,
  input  logic            inst_ready
`ifdef INST_PREFETCH_PERF_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [Mbit-1:0] ALIGN_MASK = ~(Mbit'(3));

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state, state_n;
  logic [Mbit-1:0] fetch_pc, fetch_pc_n, adr_n;
  logic [Mbit-1:0] data_q [DEPTH];
  logic [Mbit-1:0] pc_q   [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count, count_after;
  logic [Mbit-1:0] rpc, adr_plus4;
  logic            push, pop;

  assign rpc        = redirect_pc & ALIGN_MASK;
  assign adr_plus4  = mem_adr + Mbit'(4);
  assign inst_valid = (count != '0);
  assign inst       = data_q[rd_ptr];
  assign inst_pc    = pc_q[rd_ptr];
  assign pop        = inst_valid & inst_ready & ~redirect;
  // Occupancy after this cycle's push, used to decide whether to keep streaming.
  assign count_after = count + (PW+1)'(1) - (PW+1)'(pop);

  always_comb begin
    state_n    = state;
    adr_n      = mem_adr;
    fetch_pc_n = fetch_pc;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          state_n    = REQ;
          adr_n      = rpc;
          fetch_pc_n = rpc;
        end else if (count < DEPTH_C) begin
          state_n = REQ;
          adr_n   = fetch_pc;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_n = rpc;
          if (mem_ack) adr_n = rpc;
          else         state_n = DROP;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_n = adr_plus4;
          if (count_after < DEPTH_C) adr_n = adr_plus4;
          else                       state_n = IDLE;
        end
      end
      DROP: begin
        // The in-flight read belongs to a stale path; wait it out, then fetch the new one.
        if (redirect) fetch_pc_n = rpc;
        if (mem_ack) begin
          state_n = REQ;
          adr_n   = redirect ? rpc : fetch_pc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_adr  <= '0;
      fetch_pc <= start_pc & ALIGN_MASK;
    end else begin
      state    <= state_n;
      mem_req  <= (state_n != IDLE);
      mem_adr  <= adr_n;
      fetch_pc <= fetch_pc_n;
    end
  end

  // A redirect empties the queue and drops any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= mem_data;
        pc_q[wr_ptr]   <= mem_adr;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

`ifdef INST_PREFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)    fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed self-checking bench for inst_prefetch; memory returns each word as its address XOR KEY.
module tb_inst_prefetch;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset, redirect, mem_req, mem_ack, inst_valid, inst_ready;
  logic [31:0] start_pc, redirect_pc, mem_adr, mem_data, inst, inst_pc;
`ifdef INST_PREFETCH_PERF_EN
  logic [31:0] fetch_count;
`endif
  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  assign mem_data = mem_adr ^ KEY;

  inst_prefetch #(.Mbit(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef INST_PREFETCH_PERF_EN
    , .fetch_count(fetch_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic red, input logic [31:0] rpc,
                               input logic ack, input logic rdy);
    reset       = rst;
    redirect    = red;
    redirect_pc = rpc;
    mem_ack     = ack;
    inst_ready  = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic doReset(input logic [31:0] spc, input logic ack, input logic rdy);
    start_pc = spc;
    applyStimulus(1'b1, 1'b0, 32'h0, ack, rdy);
    tick();
    tick();
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_adr", mem_adr, 32'h0);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // Streaming fetch with the core always ready.
    doReset(32'h100, 1'b1, 1'b1);
    tick();
    checkOutput("s1_req", 32'(mem_req), 32'd1);
    checkOutput("s1_adr0", mem_adr, 32'h100);
    checkOutput("s1_valid0", 32'(inst_valid), 32'd0);
    tick();
    checkOutput("s1_adr1", mem_adr, 32'h104);
    checkOutput("s1_valid1", 32'(inst_valid), 32'd1);
    checkOutput("s1_pc1", inst_pc, 32'h100);
    checkOutput("s1_inst1", inst, 32'h100 ^ KEY);
    tick();
    checkOutput("s1_adr2", mem_adr, 32'h108);
    checkOutput("s1_pc2", inst_pc, 32'h104);

    // Core stalled: FIFO fills to four and fetch stops, then resumes at 0x110.
    doReset(32'h100, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("s2_req_full", 32'(mem_req), 32'd0);
    checkOutput("s2_head_pc", inst_pc, 32'h100);
    tick();
    checkOutput("s2_hold_pc", inst_pc, 32'h100);
    checkOutput("s2_hold_inst", inst, 32'h100 ^ KEY);
    checkOutput("s2_hold_req", 32'(mem_req), 32'd0);
    inst_ready = 1'b1;
    tick();
    checkOutput("s2_pop_pc", inst_pc, 32'h104);
    inst_ready = 1'b0;
    tick();
    checkOutput("s2_refetch_req", 32'(mem_req), 32'd1);
    checkOutput("s2_refetch_adr", mem_adr, 32'h110);

    // Redirect while the 0x108 read is outstanding and its ack is late.
    doReset(32'h100, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("s3_adr108", mem_adr, 32'h108);
    applyStimulus(1'b0, 1'b1, 32'h2000, 1'b0, 1'b1);
    tick();
    checkOutput("s3_drop_valid", 32'(inst_valid), 32'd0);
    checkOutput("s3_drop_adr", mem_adr, 32'h108);
    checkOutput("s3_drop_req", 32'(mem_req), 32'd1);
    redirect = 1'b0;
    tick();
    tick();
    checkOutput("s3_wait_valid", 32'(inst_valid), 32'd0);
    checkOutput("s3_wait_adr", mem_adr, 32'h108);
    mem_ack = 1'b1;
    tick();
    checkOutput("s3_new_adr", mem_adr, 32'h2000);
    checkOutput("s3_still_empty", 32'(inst_valid), 32'd0);
    tick();
    checkOutput("s3_new_valid", 32'(inst_valid), 32'd1);
    checkOutput("s3_new_pc", inst_pc, 32'h2000);
    checkOutput("s3_new_inst", inst, 32'h2000 ^ KEY);

    // Redirect coinciding with an ack and a pop; low address bits are dropped.
    applyStimulus(1'b0, 1'b1, 32'h3001, 1'b1, 1'b1);
    tick();
    checkOutput("s4_empty", 32'(inst_valid), 32'd0);
    checkOutput("s4_req", 32'(mem_req), 32'd1);
    checkOutput("s4_adr", mem_adr, 32'h3000);
    redirect = 1'b0;
    tick();
    checkOutput("s4_pc", inst_pc, 32'h3000);
    checkOutput("s4_next_adr", mem_adr, 32'h3004);

    // Reset while a request is outstanding abandons it.
    mem_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checkOutput("s5_req", 32'(mem_req), 32'd0);
    checkOutput("s5_valid", 32'(inst_valid), 32'd0);

    // Address wrap at the top of memory.
    doReset(32'hFFFF_FFF8, 1'b1, 1'b1);
    tick();
    checkOutput("s6_adr0", mem_adr, 32'hFFFF_FFF8);
    tick();
    checkOutput("s6_adr1", mem_adr, 32'hFFFF_FFFC);
    tick();
    checkOutput("s6_adr2", mem_adr, 32'h0000_0000);
    checkOutput("s6_pc", inst_pc, 32'hFFFF_FFFC);

`ifdef INST_PREFETCH_PERF_EN
    // Ten pop attempts, one of them cancelled by a redirect.
    doReset(32'h100, 1'b1, 1'b1);
    checkOutput("p_rst_count", fetch_count, 32'd0);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("p_count5", fetch_count, 32'd5);
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b1, 1'b1);
    tick();
    checkOutput("p_redirect_count", fetch_count, 32'd5);
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("p_count9", fetch_count, 32'd9);
    reset = 1'b1;
    tick();
    checkOutput("p_reset_count", fetch_count, 32'd0);
    checkOutput("p_reset_req", 32'(mem_req), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
